// File: rtl/powerup_timer_bank.sv
// powerup_timer_bank: per-player power-up timers with use counters,
// refills, cancel, and optional single-holder (exclusive) arbitration.
module powerup_timer_bank #(
  parameter int NUM_CH        = 2,
  parameter int TICKS_PER_SEC = 12,
  parameter int ACTIVE_TIME   = 3,
  parameter int COOLDOWN_TIME = 10,
  parameter int MAX_USES      = 7,
  parameter int INIT_USES     = 4,
  parameter int EXCLUSIVE     = 0
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_CH-1:0]                        request,
  input  logic [NUM_CH-1:0]                        cancel,
  input  logic [NUM_CH-1:0]                        refill,
  output logic [NUM_CH-1:0]                        enable,
  output logic [NUM_CH-1:0]                        grant,
  output logic [NUM_CH-1:0]                        ready,
  output logic [NUM_CH*$clog2(MAX_USES+1)-1:0]     uses_left
);

  localparam int UW = $clog2(MAX_USES + 1);
  localparam int AT = TICKS_PER_SEC * ACTIVE_TIME;
  localparam int CT = TICKS_PER_SEC * COOLDOWN_TIME;
  localparam int MT = (AT > CT) ? AT : CT;
  localparam int CW = (MT > 1) ? $clog2(MT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    COOLDOWN
  } state_t;

  state_t          st   [NUM_CH];
  logic [CW-1:0]   cnt  [NUM_CH];
  logic [UW-1:0]   uses [NUM_CH];

  logic [NUM_CH-1:0] cand;
  logic [NUM_CH-1:0] is_act;
  logic [NUM_CH-1:0] go;
  logic              any_act;
  logic              blk;

  // A channel may start when idle, or on the edge its cooldown expires.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      is_act[i] = (st[i] == ACTIVE);
      cand[i]   = request[i] && (uses[i] != '0) &&
                  ((st[i] == IDLE) ||
                   ((st[i] == COOLDOWN) && (cnt[i] == '0)));
    end
    any_act = |is_act;
  end

  // Fixed-priority arbitration; lowest index wins in exclusive mode.
  always_comb begin
    go  = '0;
    blk = (EXCLUSIVE != 0) && any_act;
    for (int i = 0; i < NUM_CH; i++) begin
      go[i] = cand[i] && !blk;
      blk   = blk || ((EXCLUSIVE != 0) && go[i]);
    end
  end

  // Status outputs derived from registered state.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ready[i] = (st[i] == IDLE) && (uses[i] != '0) &&
                 !((EXCLUSIVE != 0) && any_act);
      uses_left[i*UW +: UW] = uses[i];
    end
  end

  // Per-channel FSM, tick counter, use counter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        st[i]   <= IDLE;
        cnt[i]  <= '0;
        uses[i] <= UW'(INIT_USES);
      end
      enable <= '0;
      grant  <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        grant[i] <= go[i];
        unique case (st[i])
          IDLE: begin
            if (go[i]) begin
              st[i]     <= ACTIVE;
              cnt[i]    <= CW'(AT - 1);
              enable[i] <= 1'b1;
            end
          end
          ACTIVE: begin
            if ((cnt[i] == '0) || cancel[i]) begin
              st[i]     <= COOLDOWN;
              cnt[i]    <= CW'(CT - 1);
              enable[i] <= 1'b0;
            end else begin
              cnt[i] <= cnt[i] - 1'b1;
            end
          end
          COOLDOWN: begin
            if (cnt[i] == '0) begin
              if (go[i]) begin
                st[i]     <= ACTIVE;
                cnt[i]    <= CW'(AT - 1);
                enable[i] <= 1'b1;
              end else begin
                st[i] <= IDLE;
              end
            end else begin
              cnt[i] <= cnt[i] - 1'b1;
            end
          end
          default: begin
            st[i]     <= IDLE;
            cnt[i]    <= '0;
            enable[i] <= 1'b0;
          end
        endcase
        if (go[i] && !refill[i]) begin
          uses[i] <= uses[i] - 1'b1;
        end else if (!go[i] && refill[i] &&
                     (uses[i] != UW'(MAX_USES))) begin
          uses[i] <= uses[i] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_powerup_timer_bank.sv
// tb_powerup_timer_bank: scoreboard bench for powerup_timer_bank,
// one shared-level instance and one exclusive instance.
module tb_powerup_timer_bank;

  localparam int EN = 0;
  localparam int GR = 1;
  localparam int RD = 2;
  localparam int US = 3;

  typedef struct {
    int    cyc;
    int    d;
    int    sig;
    int    ch;
    int    val;
    string tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] request = '0;
  logic [1:0] cancel = '0;
  logic [1:0] refill = '0;

  logic [1:0] en_a, gr_a, rdy_a;
  logic [5:0] ul_a;
  logic [1:0] en_b, gr_b, rdy_b;
  logic [5:0] ul_b;

  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  exp_t sbq[$];

  powerup_timer_bank #(.EXCLUSIVE(0)) u_a (
    .clk(clk), .reset(reset), .request(request),
    .cancel(cancel), .refill(refill), .enable(en_a),
    .grant(gr_a), .ready(rdy_a), .uses_left(ul_a)
  );

  powerup_timer_bank #(.EXCLUSIVE(1)) u_b (
    .clk(clk), .reset(reset), .request(request),
    .cancel(cancel), .refill(refill), .enable(en_b),
    .grant(gr_b), .ready(rdy_b), .uses_left(ul_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, int got, int exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int obs(int d, int s, int ch);
    logic [1:0] e, g, r;
    logic [5:0] u;
    e = (d == 0) ? en_a : en_b;
    g = (d == 0) ? gr_a : gr_b;
    r = (d == 0) ? rdy_a : rdy_b;
    u = (d == 0) ? ul_a : ul_b;
    case (s)
      EN:      return int'(e[ch]);
      GR:      return int'(g[ch]);
      RD:      return int'(r[ch]);
      default: return int'((u >> (3 * ch)) & 6'd7);
    endcase
  endfunction

  // Compare every expectation that falls due on this cycle.
  always @(negedge clk) begin
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].cyc <= cyc) begin
        chk(sbq[i].tag, obs(sbq[i].d, sbq[i].sig, sbq[i].ch),
            sbq[i].val);
        sbq.delete(i);
      end
    end
  end

  task automatic push(int d, int s, int ch, int c, int v, string t);
    exp_t e;
    e.cyc = c;
    e.d   = d;
    e.sig = s;
    e.ch  = ch;
    e.val = v;
    e.tag = $sformatf("%s@%0d", t, c);
    sbq.push_back(e);
  endtask

  task automatic span(int d, int s, int ch, int c0, int c1,
                      int v, string t);
    for (int c = c0; c <= c1; c++) push(d, s, ch, c, v, t);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_until(int c);
    while (cyc < c) tick();
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    request = '0;
    cancel  = '0;
    refill  = '0;
    tick();
    tick();
    chk("rst_en_a", int'(en_a), 0);
    chk("rst_gr_a", int'(gr_a), 0);
    chk("rst_rdy_a", int'(rdy_a), 3);
    chk("rst_uses_a", int'(ul_a), 36);
    chk("rst_en_b", int'(en_b), 0);
    chk("rst_rdy_b", int'(rdy_b), 3);
    chk("rst_uses_b", int'(ul_b), 36);
    reset = 1'b0;
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int k, n;

    // Single request pulse on ch0.
    do_reset();
    n = cyc;
    k = n + 1;
    request[0] = 1'b1;
    push(0, US, 0, n, 4, "t1_uses_pre");
    push(0, RD, 0, n, 1, "t1_rdy_pre");
    push(0, GR, 0, k, 1, "t1_gr");
    push(0, GR, 0, k + 1, 0, "t1_gr_end");
    push(0, GR, 1, k, 0, "t1_gr1");
    push(0, RD, 1, k, 1, "t1_rdy1");
    span(0, EN, 0, k, k + 35, 1, "t1_en");
    push(0, EN, 0, k + 36, 0, "t1_en_off");
    push(0, US, 0, k, 3, "t1_uses");
    push(0, RD, 0, k, 0, "t1_rdy_lo");
    push(0, RD, 0, k + 155, 0, "t1_rdy_lo_end");
    push(0, RD, 0, k + 156, 1, "t1_rdy_back");
    tick();
    request = '0;
    wait_until(k + 160);

    // Held request: regrants every 156 cycles until uses run out.
    do_reset();
    k = cyc + 1;
    request[0] = 1'b1;
    for (int g = 0; g < 4; g++) begin
      push(0, GR, 0, k + 156 * g, 1, "t2_gr");
      push(0, US, 0, k + 156 * g, 3 - g, "t2_uses");
      if (g > 0) push(0, GR, 0, k + 156 * g - 1, 0, "t2_gr_early");
    end
    push(0, GR, 0, k + 624, 0, "t2_no_gr");
    push(0, GR, 0, k + 700, 0, "t2_no_gr_late");
    push(0, RD, 0, k + 624, 0, "t2_rdy_empty");
    push(0, US, 0, k + 700, 0, "t2_uses_empty");
    push(0, EN, 0, k + 700, 0, "t2_en_off");
    wait_until(k + 702);
    request = '0;

    // Cancel on the 10th active cycle, then earliest regrant.
    do_reset();
    k = cyc + 1;
    request[0] = 1'b1;
    push(0, EN, 0, k + 9, 1, "t3_en_last");
    push(0, EN, 0, k + 10, 0, "t3_en_cut");
    push(0, US, 0, k + 10, 3, "t3_no_refund");
    push(0, EN, 0, k + 129, 0, "t3_cool_en");
    push(0, RD, 0, k + 129, 0, "t3_cool_rdy");
    push(0, GR, 0, k + 129, 0, "t3_cool_gr");
    push(0, GR, 0, k + 130, 1, "t3_regrant");
    push(0, US, 0, k + 130, 2, "t3_uses2");
    push(0, EN, 0, k + 130, 1, "t3_en_again");
    tick();
    request = '0;
    wait_until(k + 9);
    cancel[0] = 1'b1;
    tick();
    cancel[0] = 1'b0;
    wait_until(k + 50);
    cancel[0] = 1'b1;
    tick();
    cancel[0] = 1'b0;
    wait_until(k + 129);
    request[0] = 1'b1;
    tick();
    request = '0;
    wait_until(k + 132);

    // Refill saturation, and refill coinciding with a grant.
    do_reset();
    n = cyc;
    refill[1] = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      push(0, US, 1, n + j, (4 + j > 7) ? 7 : 4 + j, "t4_refill");
    end
    wait_until(n + 5);
    refill = '0;
    k = cyc + 1;
    request = 2'b11;
    refill  = 2'b11;
    push(0, GR, 1, k, 1, "t4_gr1");
    push(0, US, 1, k, 7, "t4_uses1_same");
    push(0, GR, 0, k, 1, "t4_gr0");
    push(0, US, 0, k, 4, "t4_uses0_same");
    push(0, US, 0, k + 4, 5, "t4_refill_active");
    push(0, EN, 0, k + 4, 1, "t4_en0");
    tick();
    request = '0;
    refill  = '0;
    wait_until(k + 3);
    refill[0] = 1'b1;
    tick();
    refill = '0;
    wait_until(k + 6);

    // Simultaneous requests: exclusive vs shared instance.
    do_reset();
    k = cyc + 1;
    request = 2'b11;
    push(0, GR, 1, k, 1, "t5_shared_gr1");
    push(1, GR, 0, k, 1, "t5_x_gr0");
    push(1, GR, 1, k, 0, "t5_x_gr1_lose");
    push(1, RD, 1, k, 0, "t5_x_rdy1_blk");
    push(1, US, 0, k, 3, "t5_x_uses0");
    span(1, EN, 0, k, k + 35, 1, "t5_x_en0");
    span(1, EN, 1, k, k + 36, 0, "t5_x_en1_off");
    push(1, EN, 0, k + 36, 0, "t5_x_en0_off");
    push(1, GR, 1, k + 36, 0, "t5_x_gr1_blk");
    push(1, US, 1, k + 36, 4, "t5_x_uses1_hold");
    push(1, RD, 1, k + 36, 1, "t5_x_rdy1");
    push(1, GR, 1, k + 37, 1, "t5_x_gr1");
    push(1, US, 1, k + 37, 3, "t5_x_uses1");
    push(1, EN, 1, k + 37, 1, "t5_x_en1");
    push(1, GR, 0, k + 156, 1, "t5_x_regr0");
    push(1, US, 0, k + 156, 2, "t5_x_uses0b");
    wait_until(k + 158);
    request = '0;

    // Asynchronous reset while active.
    do_reset();
    k = cyc + 1;
    request[0] = 1'b1;
    push(0, EN, 0, k + 4, 1, "t6_en_pre");
    push(0, US, 0, k + 4, 3, "t6_uses_pre");
    tick();
    request = '0;
    wait_until(k + 5);
    #1;
    reset = 1'b1;
    #1;
    chk("t6_act_en_a", int'(en_a[0]), 0);
    chk("t6_act_en_b", int'(en_b[0]), 0);
    chk("t6_act_uses", int'(ul_a[2:0]), 4);
    tick();
    reset = 1'b0;
    tick();

    // Asynchronous reset during cooldown.
    k = cyc + 1;
    request[0] = 1'b1;
    push(0, RD, 0, k + 60, 0, "t6_cool_rdy_pre");
    push(0, US, 0, k + 60, 3, "t6_cool_uses_pre");
    tick();
    request = '0;
    wait_until(k + 61);
    #1;
    reset = 1'b1;
    #1;
    chk("t6_cool_rdy", int'(rdy_a[0]), 1);
    chk("t6_cool_uses", int'(ul_a[2:0]), 4);
    chk("t6_cool_en", int'(en_a[0]), 0);
    tick();
    reset = 1'b0;
    tick();
    tick();

    chk("sb_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
